median_rank_pipe: RTL and testbench
===================================

MEDIAN_RANK_PIPE -- requirements
Module: median_rank_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, bits per channel sample.
REQ-002 SHALL have parameter CH, default 1, independent channels per pixel (e.g. 3 for RGB).
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  in  1  window word present.
REQ-006 SHALL have port in_ready  out  1  window accepted when in_valid&&in_ready.
REQ-007 SHALL have port in_win  in  9*CH*DATA_W  3x3 window; pixel k at [k*CH*DATA_W +: CH*DATA_W], k=4 is centre; channel c of a pixel at [c*DATA_W +: DATA_W].
REQ-008 SHALL have port in_rank  in  2  selection: 0=min, 1=median, 2=max, 3=median.
REQ-009 SHALL have port out_valid  out  1  result present.
REQ-010 SHALL have port out_ready  in  1  result consumed when out_valid&&out_ready.
REQ-011 SHALL have port out_px  out  CH*DATA_W  selected value per channel.
REQ-012 SHALL have port out_bypass  out  1  result is passed-through centre pixel (tied 0 when REQ-031 disabled).

Function
REQ-013 SHALL sort each channel independently with a 9-input unsigned sorting network; channels never interact.
REQ-014 SHALL register inputs (stage 0) and then register after each of 9 compare-exchange stages; the 10 stages carry data, valid and rank.
REQ-015 SHALL produce out_valid exactly 10 cycles after an accepted input when out_ready stays 1.
REQ-016 SHALL accept one window per cycle at full throughput, with no bubbles while out_ready=1.
REQ-017 SHALL hold the whole pipeline (no register updates) while out_valid=1 and out_ready=0.
REQ-018 SHALL drive in_ready = !(out_valid && !out_ready); in_ready is combinational and depends on no input other than out_ready.
REQ-019 SHALL let bubbles (stages with valid=0) advance during a stall only if no valid stage lies downstream of them; otherwise, a simple global stall is acceptable, and bubbles are not compressed.
REQ-020 SHALL capture in_rank with its window and apply it at the output stage, so rank can change every sample.
REQ-021 SHALL output sorted[0] for rank 0, sorted[4] for ranks 1 and 3, and sorted[8] for rank 2, per channel.
REQ-022 SHALL produce the correct order statistic with equal values; tie order is don't-care.
REQ-023 SHALL hold out_px and out_bypass stable while out_valid=1 and out_ready=0.
REQ-024 SHALL leave out_px as don't-care when out_valid=0, while still holding the last value.
REQ-025 SHALL ignore in_win and in_rank when in_valid=0 or in_ready=0.

Reset
REQ-026 SHALL, on rst assertion, clear all stage valid bits, out_valid, out_px and out_bypass to 0 asynchronously.
REQ-027 SHALL discard in-flight windows when rst is asserted mid-stream; no result from them appears after reset.
REQ-028 SHALL drive in_ready=1 during reset and in the first cycle after deassertion.
REQ-029 SHALL treat data registers as resettable to 0.

Configuration
REQ-030 SHALL use macro NOISE_BYPASS_EN to control impulse detection.
REQ-031 SHALL, with NOISE_BYPASS_EN defined and rank 1/3, output the unfiltered centre pixel with out_bypass=1 for that sample when no channel of it equals 0 or 2^DATA_W-1.
REQ-032 SHALL otherwise output the median with out_bypass=0.
REQ-033 SHALL, without NOISE_BYPASS_EN, omit the detection logic, tie out_bypass to 0, and always apply REQ-021.
REQ-034 SHALL apply the same latency (REQ-015) in both builds; the centre pixel is pipelined alongside the sort.

Verification
REQ-035 SHALL cover: CH=1, window {9,1,8,2,7,3,6,4,5}, rank 1 -> out_px=5 at cycle 10, out_bypass=0 (macro off).
REQ-036 SHALL cover: same window, ranks 0 then 2 on back-to-back cycles -> out_px=1 then 9 on consecutive cycles.
REQ-037 SHALL cover: CH=3, pixels whose channel c = k+10c for k=0..8 (windows shuffled) -> out_px per channel {4,14,24}.
REQ-038 SHALL cover: 20 back-to-back windows, out_ready low cycles 12-15 -> out_px held, in_ready=0 in those cycles, all 20 results in order, none lost or duplicated.
REQ-039 SHALL cover: rst pulse with 5 windows in flight -> out_valid=0 until 10 cycles after the next accepted window.
REQ-040 SHALL cover: NOISE_BYPASS_EN, centre=100, others {0,255,0,255,0,255,0,255} -> out_px=100, out_bypass=1; same with centre=255 -> median 255, out_bypass=0.

Source files
------------

// File: rtl/median_rank_pipe.sv
// median_rank_pipe: per-channel 3x3 rank filter (min / median / max) built on a
// 9-round odd-even transposition sorting network. Optional impulse bypass: NOISE_BYPASS_EN.
module median_rank_pipe #(
    parameter int DATA_W = 8,
    parameter int CH     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [9*CH*DATA_W-1:0] in_win,
    input  logic [1:0]             in_rank,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CH*DATA_W-1:0]   out_px,
    output logic                   out_bypass
);
    localparam int NS = 10;  // stage 0 capture + 9 compare-exchange rounds

    // A pixel packs its channels; a window packs its 9 pixels, matching in_win.
    typedef logic [CH-1:0][DATA_W-1:0] pixel_t;
    typedef pixel_t [8:0]              window_t;

    logic [NS-1:0]           st_v;
    logic [NS-1:0][1:0]      st_r;
    window_t [NS-1:0]        st_d;
    window_t [NS-1:1]        nx_d;
    pixel_t                  sel;
    logic                    advance;
    logic                    unused_sorted;

    // Global stall: nothing moves while a result waits on the consumer.
    assign advance   = !(st_v[NS-1] && !out_ready);
    assign in_ready  = advance;
    assign out_valid = st_v[NS-1];

    // Round s compares pairs (0,1),(2,3).. when s is odd and (1,2),(3,4).. when
    // even; nine alternating rounds fully sort nine values, channel by channel.
    always_comb begin
        for (int s = 1; s < NS; s++) begin
            nx_d[s] = st_d[s-1];
            for (int p = 0; p < 8; p++) begin
                if ((p % 2) == ((s - 1) % 2)) begin
                    for (int c = 0; c < CH; c++) begin
                        if (st_d[s-1][p][c] > st_d[s-1][p+1][c]) begin
                            nx_d[s][p][c]   = st_d[s-1][p+1][c];
                            nx_d[s][p+1][c] = st_d[s-1][p][c];
                        end
                    end
                end
            end
        end
    end

    // NOTE: data registers are reset along with the valid bits so that out_px,
    // which is decoded straight from the last stage, reads zero during reset.
    // Data only loads behind a valid word, so bubbles never overwrite a result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_v <= '0;
            st_r <= '0;
            st_d <= '0;
        end else if (advance) begin
            st_v <= {st_v[NS-2:0], in_valid};
            if (in_valid) begin
                st_d[0] <= in_win;
                st_r[0] <= in_rank;
            end
            for (int s = 1; s < NS; s++) begin
                if (st_v[s-1]) begin
                    st_d[s] <= nx_d[s];
                    st_r[s] <= st_r[s-1];
                end
            end
        end
    end

    // The sort is per channel, so each sorted position is already a whole pixel.
    always_comb begin
        sel = '0;
        case (st_r[NS-1])
            2'd0:    sel = st_d[NS-1][0];
            2'd2:    sel = st_d[NS-1][8];
            default: sel = st_d[NS-1][4];
        endcase
    end

    // Only sorted positions 0, 4 and 8 are ever selected.
    assign unused_sorted = ^{st_d[NS-1][7:5], st_d[NS-1][3:1]};

`ifdef NOISE_BYPASS_EN
    pixel_t [NS-1:1] st_c;
    logic            impulse;

    // The centre is copied out before sorting scrambles positions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_c <= '0;
        end else if (advance) begin
            if (st_v[0]) st_c[1] <= st_d[0][4];
            for (int s = 2; s < NS; s++) begin
                if (st_v[s-1]) st_c[s] <= st_c[s-1];
            end
        end
    end

    always_comb begin
        impulse = 1'b0;
        for (int c = 0; c < CH; c++) begin
            if (st_c[NS-1][c] == '0 || st_c[NS-1][c] == '1) impulse = 1'b1;
        end
    end

    // Median ranks (1 and 3) pass a clean centre through untouched.
    assign out_bypass = st_r[NS-1][0] && !impulse;
    assign out_px     = out_bypass ? st_c[NS-1] : sel;
`else
    assign out_bypass = 1'b0;
    assign out_px     = sel;
`endif

endmodule

// File: tb/tb_median_rank_pipe.sv
// Self-checking bench for median_rank_pipe: a CH=1 and a CH=3 instance driven by
// directed steps, with scoreboards fed from an independent counting-rank model.
module tb_median_rank_pipe;
    localparam int DW = 8;

`ifdef NOISE_BYPASS_EN
    localparam logic [8:0] A_MED   = {1'b1, 8'd7};
    localparam logic [8:0] IMP_MED = {1'b1, 8'd100};
`else
    localparam logic [8:0] A_MED   = {1'b0, 8'd5};
    localparam logic [8:0] IMP_MED = {1'b0, 8'd100};
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            v1 = 1'b0, ordy1 = 1'b1;
    logic            rdy1, ov1, byp1;
    logic [9*DW-1:0] win1 = '0;
    logic [1:0]      rank1 = '0;
    logic [DW-1:0]   px1;

    logic             v3 = 1'b0, ordy3 = 1'b1;
    logic             rdy3, ov3, byp3;
    logic [27*DW-1:0] win3 = '0;
    logic [1:0]       rank3 = '0;
    logic [3*DW-1:0]  px3;

    median_rank_pipe #(.DATA_W(DW), .CH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_win(win1),
        .in_rank(rank1), .out_valid(ov1), .out_ready(ordy1), .out_px(px1),
        .out_bypass(byp1)
    );

    median_rank_pipe #(.DATA_W(DW), .CH(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .in_win(win3),
        .in_rank(rank3), .out_valid(ov3), .out_ready(ordy3), .out_px(px3),
        .out_bypass(byp3)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [24:0] q1[$];
    logic [24:0] q3[$];
    logic [24:0] e1, e3;
    bit          stall_en = 1'b0;
    int          stall_lo = 0, stall_hi = 0;
    logic [DW-1:0] px_hold = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Order statistic by counting: v[k] is sorted[idx] when lt <= idx < le.
    function automatic logic [24:0] model(input logic [27*DW-1:0] w, input int ch,
                                          input logic [1:0] r);
        logic [23:0]   px;
        logic          byp;
        logic [DW-1:0] v [9];
        logic [DW-1:0] cen;
        int            idx, lt, le;
        px  = '0;
        byp = 1'b0;
        idx = (r == 2'd0) ? 0 : (r == 2'd2) ? 8 : 4;
        for (int c = 0; c < ch; c++) begin
            for (int k = 0; k < 9; k++) v[k] = w[(k*ch+c)*DW +: DW];
            for (int k = 0; k < 9; k++) begin
                lt = 0;
                le = 0;
                for (int j = 0; j < 9; j++) begin
                    if (v[j] < v[k]) lt++;
                    if (v[j] <= v[k]) le++;
                end
                if (lt <= idx && idx < le) px[c*DW +: DW] = v[k];
            end
        end
`ifdef NOISE_BYPASS_EN
        if (r[0]) begin
            byp = 1'b1;
            for (int c = 0; c < ch; c++) begin
                cen = w[(4*ch+c)*DW +: DW];
                if (cen == 8'h00 || cen == 8'hFF) byp = 1'b0;
            end
            if (byp) begin
                for (int c = 0; c < ch; c++) px[c*DW +: DW] = w[(4*ch+c)*DW +: DW];
            end
        end
`endif
        return {byp, px};
    endfunction

    function automatic logic [27*DW-1:0] rand_win();
        logic [27*DW-1:0] w;
        w = '0;
        for (int i = 0; i < 27; i++) begin
            case ($urandom_range(0, 7))
                0:       w[i*DW +: DW] = 8'h00;
                1:       w[i*DW +: DW] = 8'hFF;
                default: w[i*DW +: DW] = 8'($urandom);
            endcase
        end
        return w;
    endfunction

    // Channel c of pixel k holds ((k*m_c + s) mod 9) + 10c: a per-channel shuffle.
    function automatic logic [27*DW-1:0] perm_win(input int s);
        logic [27*DW-1:0] w;
        int m;
        w = '0;
        for (int c = 0; c < 3; c++) begin
            m = (c == 0) ? 2 : (c == 1) ? 4 : 7;
            for (int k = 0; k < 9; k++) w[(k*3+c)*DW +: DW] = 8'(((k*m + s) % 9) + 10*c);
        end
        return w;
    endfunction

    task automatic send1(input logic [9*DW-1:0] w, input logic [1:0] r, input bit push,
                         output int t);
        int n;
        n = 0;
        @(negedge clk);
        v1 = 1'b1; win1 = w; rank1 = r;
        #1;
        while (rdy1 !== 1'b1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("dut1_accept", 32'(rdy1), 32'd1);
        t = cyc;
        if (push) q1.push_back(model({144'b0, w}, 1, r));
    endtask

    task automatic send3(input logic [27*DW-1:0] w, input logic [1:0] r, output int t);
        int n;
        n = 0;
        @(negedge clk);
        v3 = 1'b1; win3 = w; rank3 = r;
        #1;
        while (rdy3 !== 1'b1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("dut3_accept", 32'(rdy3), 32'd1);
        t = cyc;
        q3.push_back(model(w, 3, r));
    endtask

    // Idle inputs carry junk that must be ignored.
    task automatic idle1();
        logic [27*DW-1:0] w;
        w = rand_win();
        @(negedge clk);
        v1 = 1'b0; win1 = w[9*DW-1:0]; rank1 = 2'($urandom_range(0, 3));
    endtask

    task automatic idle3();
        @(negedge clk);
        v3 = 1'b0; win3 = rand_win(); rank3 = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_cyc(input int due);
        while (cyc < due) @(negedge clk);
        #1;
    endtask

    always @(negedge clk) ordy1 = !(stall_en && cyc >= stall_lo && cyc <= stall_hi);

    always @(negedge clk) begin
        #2;
        if (!rst && ov1 === 1'b1 && ordy1) begin
            if (q1.size() == 0) check("dut1_unexpected_out", 32'(ov1), 32'd0);
            else begin
                e1 = q1.pop_front();
                check("dut1_sb", 32'({byp1, px1}), 32'({e1[24], e1[7:0]}));
            end
        end
        if (!rst && ov3 === 1'b1 && ordy3) begin
            if (q3.size() == 0) check("dut3_unexpected_out", 32'(ov3), 32'd0);
            else begin
                e3 = q3.pop_front();
                check("dut3_sb", 32'({byp3, px3}), 32'(e3));
            end
        end
    end

    always @(negedge clk) begin
        #3;
        if (stall_en && cyc >= stall_lo - 2 && cyc <= stall_hi + 1) begin
            check("stall_in_ready", 32'(rdy1), 32'(!(cyc >= stall_lo && cyc <= stall_hi)));
            if (cyc == stall_lo) px_hold = px1;
            else if (cyc > stall_lo && cyc <= stall_hi)
                check("stall_hold", 32'({ov1, px1}), 32'({1'b1, px_hold}));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, t1, t;
        logic [9*DW-1:0]  w_a, w_imp, w_sat;
        logic [27*DW-1:0] rw;
        w_a   = {8'd5, 8'd4, 8'd6, 8'd3, 8'd7, 8'd2, 8'd8, 8'd1, 8'd9};
        w_imp = {8'd255, 8'd0, 8'd255, 8'd0, 8'd100, 8'd255, 8'd0, 8'd255, 8'd0};
        w_sat = {8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd0};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready1", 32'(rdy1), 32'd1);
        check("rst_out_valid1", 32'(ov1), 32'd0);
        check("rst_out_px1", 32'(px1), 32'd0);
        check("rst_bypass1", 32'(byp1), 32'd0);
        check("rst_in_ready3", 32'(rdy3), 32'd1);
        check("rst_out_valid3", 32'(ov3), 32'd0);
        check("rst_out_px3", 32'(px3), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(rdy1), 32'd1);

        // Single median, exact latency
        send1(w_a, 2'd1, 1'b1, t0);
        idle1();
        wait_cyc(t0 + 9);
        check("lat_not_early", 32'(ov1), 32'd0);
        wait_cyc(t0 + 10);
        check("lat_median", 32'({ov1, byp1, px1}), 32'({1'b1, A_MED}));
        wait_cyc(t0 + 11);
        check("single_no_dup", 32'(ov1), 32'd0);

        // Rank changes every sample: min then max back to back
        send1(w_a, 2'd0, 1'b1, t0);
        send1(w_a, 2'd2, 1'b1, t1);
        idle1();
        check("b2b_accept", 32'(t1 - t0), 32'd1);
        wait_cyc(t0 + 10);
        check("b2b_min", 32'({ov1, byp1, px1}), 32'({1'b1, 1'b0, 8'd1}));
        wait_cyc(t0 + 11);
        check("b2b_max", 32'({ov1, byp1, px1}), 32'({1'b1, 1'b0, 8'd9}));
        wait_cyc(t0 + 12);
        check("b2b_end", 32'(ov1), 32'd0);

        // Impulse bypass windows
        send1(w_imp, 2'd1, 1'b1, t0);
        send1(w_imp, 2'd0, 1'b1, t1);
        send1(w_sat, 2'd3, 1'b1, t1);
        idle1();
        wait_cyc(t0 + 10);
        check("imp_centre100", 32'({ov1, byp1, px1}), 32'({1'b1, IMP_MED}));
        wait_cyc(t0 + 11);
        check("imp_rank0", 32'({ov1, byp1, px1}), 32'({1'b1, 1'b0, 8'd0}));
        wait_cyc(t0 + 12);
        check("imp_centre255", 32'({ov1, byp1, px1}), 32'({1'b1, 1'b0, 8'd255}));

        // 20 back-to-back windows, consumer stalls cycles 12..15
        for (int i = 0; i < 20; i++) begin
            rw = rand_win();
            send1(rw[9*DW-1:0], 2'($urandom_range(0, 3)), 1'b1, t);
            if (i == 0) begin
                t0 = t;
                stall_lo = t + 12;
                stall_hi = t + 15;
                stall_en = 1'b1;
            end
        end
        idle1();
        wait_cyc(t0 + 45);
        stall_en = 1'b0;
        check("stall_drained", 32'(q1.size()), 32'd0);

        // Reset with 5 windows in flight
        for (int i = 0; i < 5; i++) send1(w_a, 2'd2, 1'b0, t);
        @(negedge clk);
        rst = 1'b1;
        v1  = 1'b0;
        #1;
        check("midrst_out_valid", 32'(ov1), 32'd0);
        check("midrst_out_px", 32'(px1), 32'd0);
        check("midrst_in_ready", 32'(rdy1), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_ready_after", 32'(rdy1), 32'd1);
        repeat (12) begin
            @(negedge clk);
            #1;
            check("midrst_no_ghost", 32'(ov1), 32'd0);
        end
        send1(w_a, 2'd0, 1'b1, t0);
        idle1();
        wait_cyc(t0 + 9);
        check("post_rst_not_early", 32'(ov1), 32'd0);
        wait_cyc(t0 + 10);
        check("post_rst_first", 32'({ov1, px1}), 32'({1'b1, 8'd1}));

        // CH=3: independent per-channel shuffles, ranks 1,0,2,3 back to back
        send3(perm_win(1), 2'd1, t0);
        send3(perm_win(3), 2'd0, t);
        send3(perm_win(7), 2'd2, t);
        send3(perm_win(1), 2'd3, t);
        idle3();
        wait_cyc(t0 + 10);
        check("ch3_median", 32'({ov3, byp3, px3}), 32'({1'b1, 1'b0, 8'd24, 8'd14, 8'd4}));
        wait_cyc(t0 + 11);
        check("ch3_min", 32'({ov3, byp3, px3}), 32'({1'b1, 1'b0, 8'd20, 8'd10, 8'd0}));
        wait_cyc(t0 + 12);
        check("ch3_max", 32'({ov3, byp3, px3}), 32'({1'b1, 1'b0, 8'd28, 8'd18, 8'd8}));
        wait_cyc(t0 + 13);
        check("ch3_rank3", 32'({ov3, byp3, px3}), 32'({1'b1, 1'b0, 8'd24, 8'd14, 8'd4}));

        // CH=3 random windows, saturated samples mixed in
        for (int i = 0; i < 12; i++) send3(rand_win(), 2'($urandom_range(0, 3)), t);
        idle3();
        wait_cyc(t + 14);
        check("ch3_drained", 32'(q3.size()), 32'd0);
        check("ch1_drained", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
